// File: rtl/pipelined_write_rx.sv
// Receive side of the pipelined-write link: cmd beat plus data beats in, one assembled write out.
// Optional PWR_RX_TIMEOUT_EN adds an idle-beat watchdog while collecting data.
module pipelined_write_rx #(
  parameter int MAX_WR_CYCLES  = 4,
  parameter int WR_WIDTH       = 8,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                                         clk,
  input  logic                                         rst_n,
  input  logic                                         in_vld,
  input  logic [WR_WIDTH+1:0]                          in_beat,
  output logic                                         in_rdy,
  output logic [(WR_WIDTH+2)*(MAX_WR_CYCLES+1)-1:0]    out_wr,
  output logic                                         out_vld,
  input  logic                                         out_rdy,
  output logic                                         wdone,
  output logic                                         err,
  output logic [1:0]                                   err_code
);

  localparam int BW = WR_WIDTH + 2;
  localparam int OW = BW * (MAX_WR_CYCLES + 1);
  localparam int CW = $clog2(MAX_WR_CYCLES + 1);
  localparam int IW = (MAX_WR_CYCLES > 1) ? $clog2(MAX_WR_CYCLES) : 1;

  localparam logic [2:0] WT_STD   = 3'd0;
  localparam logic [2:0] WT_MULTI = 3'd2;

  localparam logic [1:0] CT_IDLE  = 2'd0;
  localparam logic [1:0] CT_VALID = 2'd1;
  localparam logic [1:0] CT_DONE  = 2'd2;
  localparam logic [1:0] CT_BAD   = 2'd3;

  typedef enum logic {S_IDLE, S_DATA} state_e;

  state_e                         state_q, state_d;
  logic [BW-1:0]                  cmd_q, cmd_d;
  logic [0:MAX_WR_CYCLES-1][BW-1:0] slot_q, slot_d;
  logic [CW-1:0]                  cnt_q, cnt_d;
  logic [CW-1:0]                  exp_q, exp_d;
  logic [OW-1:0]                  out_wr_q, out_wr_d;
  logic                           out_vld_q, out_vld_d;
  logic                           wdone_q, wdone_d;
  logic                           err_q, err_d;
  logic [1:0]                     err_code_q, err_code_d;
`ifdef PWR_RX_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0]                  tmo_q, tmo_d;
`endif

  logic       last;
  logic       stall;
  logic       acc;
  logic [1:0] ct;
  logic [2:0] wtype;

  assign last   = (cnt_q + CW'(1)) == exp_q;
  assign stall  = (state_q == S_DATA) && last
                  && out_vld_q && !out_rdy;
  assign in_rdy = !stall;
  assign acc    = in_vld && !stall;
  assign ct     = in_beat[BW-1 -: 2];
  assign wtype  = cmd_q[2:0];

  always_comb begin
    state_d    = state_q;
    cmd_d      = cmd_q;
    slot_d     = slot_q;
    cnt_d      = cnt_q;
    exp_d      = exp_q;
    out_wr_d   = out_wr_q;
    out_vld_d  = out_vld_q;
    wdone_d    = 1'b0;
    err_d      = 1'b0;
    err_code_d = 2'd0;
`ifdef PWR_RX_TIMEOUT_EN
    tmo_d      = tmo_q;
`endif
    if (out_vld_q && out_rdy) out_vld_d = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (acc && in_beat[5]) begin
          if (in_beat[2:0] > WT_MULTI) begin
            err_d      = 1'b1;
            err_code_d = 2'd2;
          end else begin
            cmd_d   = in_beat;
            exp_d   = (in_beat[4:3] == 2'd0) ?
                      CW'(MAX_WR_CYCLES) :
                      CW'(in_beat[4:3]);
            cnt_d   = '0;
            slot_d  = '0;
            state_d = S_DATA;
`ifdef PWR_RX_TIMEOUT_EN
            tmo_d   = '0;
`endif
          end
        end
      end
      S_DATA: begin
        if (acc && ct != CT_IDLE) begin
          slot_d[cnt_q[IW-1:0]] = in_beat;
          cnt_d = cnt_q + CW'(1);
`ifdef PWR_RX_TIMEOUT_EN
          tmo_d = '0;
`endif
          unique case (1'b1)
            (ct == CT_BAD) || (ct == CT_VALID && last): begin
              err_d      = 1'b1;
              err_code_d = 2'd1;
              slot_d     = '0;
              state_d    = S_IDLE;
            end
            (ct == CT_DONE) && !last: begin
              err_d      = 1'b1;
              err_code_d = 2'd0;
              slot_d     = '0;
              state_d    = S_IDLE;
            end
            (ct == CT_DONE) && last: begin
              out_wr_d  = {cmd_q, slot_d};
              out_vld_d = 1'b1;
              wdone_d   = (wtype != WT_STD);
              slot_d    = '0;
              state_d   = S_IDLE;
            end
            default: begin
              wdone_d = (wtype == WT_MULTI);
            end
          endcase
        end
`ifdef PWR_RX_TIMEOUT_EN
        else if (tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
          err_d      = 1'b1;
          err_code_d = 2'd3;
          slot_d     = '0;
          tmo_d      = '0;
          state_d    = S_IDLE;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
`endif
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      cmd_q      <= '0;
      slot_q     <= '0;
      cnt_q      <= '0;
      exp_q      <= '0;
      out_wr_q   <= '0;
      out_vld_q  <= 1'b0;
      wdone_q    <= 1'b0;
      err_q      <= 1'b0;
      err_code_q <= 2'd0;
`ifdef PWR_RX_TIMEOUT_EN
      tmo_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      cmd_q      <= cmd_d;
      slot_q     <= slot_d;
      cnt_q      <= cnt_d;
      exp_q      <= exp_d;
      out_wr_q   <= out_wr_d;
      out_vld_q  <= out_vld_d;
      wdone_q    <= wdone_d;
      err_q      <= err_d;
      err_code_q <= err_code_d;
`ifdef PWR_RX_TIMEOUT_EN
      tmo_q      <= tmo_d;
`endif
    end
  end

  assign out_wr   = out_wr_q;
  assign out_vld  = out_vld_q;
  assign wdone    = wdone_q;
  assign err      = err_q;
  assign err_code = err_code_q;

endmodule

// File: tb/tb_pipelined_write_rx.sv
// Bench for pipelined_write_rx: directed table, corner sequences, random vs transaction model.
// Build with +define+PWR_RX_TIMEOUT_EN to exercise the watchdog.
module tb_pipelined_write_rx;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        in_vld = 1'b0;
  logic [9:0]  in_beat = '0;
  logic        in_rdy;
  logic [49:0] out_wr;
  logic        out_vld;
  logic        out_rdy = 1'b0;
  logic        wdone;
  logic        err;
  logic [1:0]  err_code;

  pipelined_write_rx dut (
    .clk(clk), .rst_n(rst_n),
    .in_vld(in_vld), .in_beat(in_beat), .in_rdy(in_rdy),
    .out_wr(out_wr), .out_vld(out_vld), .out_rdy(out_rdy),
    .wdone(wdone), .err(err), .err_code(err_code)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int wd_cnt = 0;
  logic last_rdy;

  // transaction-level reference: beats collected in a queue
  bit          m_busy;
  logic [9:0]  m_cmd;
  logic [9:0]  m_beats[$];
  int          m_exp;
  bit          m_ovld;
  logic [49:0] m_owr;
  bit          m_wd, m_er;
  logic [1:0]  m_code;
  int          m_tmo;

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic m_reset();
    m_busy = 0; m_cmd = '0; m_beats.delete(); m_exp = 0;
    m_ovld = 0; m_owr = '0; m_wd = 0; m_er = 0; m_code = 0; m_tmo = 0;
  endtask

  function automatic bit pred_rdy(bit r);
    return !(m_busy && (m_beats.size() + 1 == m_exp) && m_ovld && !r);
  endfunction

  task automatic m_abort(logic [1:0] c);
    m_er = 1; m_code = c; m_busy = 0; m_beats.delete();
  endtask

  task automatic model(bit v, logic [9:0] b, bit r, bit rdy);
    bit drained, newo, counted, was;
    int n;
    drained = m_ovld && r;
    newo = 0; counted = 0; was = m_busy;
    m_wd = 0; m_er = 0; m_code = 0;
    if (v && rdy) begin
      if (!m_busy) begin
        if (b[5]) begin
          if (b[2:0] > 3'd2) begin
            m_er = 1; m_code = 2;
          end else begin
            m_busy = 1; m_cmd = b; m_beats.delete(); m_tmo = 0;
            m_exp = (b[4:3] == 2'd0) ? 4 : int'(b[4:3]);
          end
        end
      end else if (b[9:8] != 2'd0) begin
        counted = 1;
        n = m_beats.size() + 1;
        if (b[9:8] == 2'd3 || (b[9:8] == 2'd1 && n == m_exp)) m_abort(2'd1);
        else if (b[9:8] == 2'd2 && n < m_exp) m_abort(2'd0);
        else begin
          m_beats.push_back(b);
          if (b[9:8] == 2'd2) begin
            m_owr = {m_cmd, 40'h0};
            for (int i = 0; i < m_beats.size(); i++)
              m_owr[39-10*i -: 10] = m_beats[i];
            newo = 1; m_wd = (m_cmd[2:0] != 3'd0); m_busy = 0;
          end else begin
            m_wd = (m_cmd[2:0] == 3'd2);
          end
        end
      end
    end
`ifdef PWR_RX_TIMEOUT_EN
    if (counted) m_tmo = 0;
    else if (was && m_busy) begin
      m_tmo++;
      if (m_tmo == 64) m_abort(2'd3);
    end
`endif
    if (newo) m_ovld = 1;
    else if (drained) m_ovld = 0;
  endtask

  task automatic step(bit v, logic [9:0] b, bit r);
    bit pr;
    @(negedge clk);
    in_vld = v; in_beat = b; out_rdy = r;
    #1;
    pr = pred_rdy(r);
    last_rdy = in_rdy;
    chk("in_rdy", in_rdy, pr);
    model(v, b, r, pr);
    @(posedge clk);
    #1;
    chk("out_vld", out_vld, m_ovld);
    if (m_ovld) chk("out_wr", out_wr, m_owr);
    chk("wdone", wdone, m_wd);
    chk("err", err, m_er);
    if (m_er) chk("err_code", err_code, m_code);
    if (wdone) wd_cnt++;
  endtask

  task automatic chk_reset_vals(string nm);
    chk({nm, "_in_rdy"}, in_rdy, 1);
    chk({nm, "_out_vld"}, out_vld, 0);
    chk({nm, "_out_wr"}, out_wr, 0);
    chk({nm, "_wdone"}, wdone, 0);
    chk({nm, "_err"}, err, 0);
    chk({nm, "_err_code"}, err_code, 0);
  endtask

  typedef struct {
    bit          v;
    logic [9:0]  b;
    bit          r;
    bit          e_vld;
    logic [49:0] e_wr;
    bit          e_wd;
    bit          e_er;
    logic [1:0]  e_code;
  } vec_t;

  vec_t tbl[14];

  initial begin
    logic [9:0] rb;
    logic [1:0] rct;
    bit rv, rr;

    tbl[0]  = '{1, 10'h2B0, 0, 0, 50'h0, 0, 0, 2'd0};
    tbl[1]  = '{1, 10'h1A1, 0, 0, 50'h0, 0, 0, 2'd0};
    tbl[2]  = '{0, 10'h000, 0, 0, 50'h0, 0, 0, 2'd0};
    tbl[3]  = '{1, 10'h2B2, 0, 1, {10'h2B0, 10'h1A1, 10'h2B2, 20'h0}, 0, 0, 2'd0};
    tbl[4]  = '{0, 10'h000, 0, 1, {10'h2B0, 10'h1A1, 10'h2B2, 20'h0}, 0, 0, 2'd0};
    tbl[5]  = '{0, 10'h000, 1, 0, 50'h0, 0, 0, 2'd0};
    tbl[6]  = '{1, 10'h025, 1, 0, 50'h0, 0, 1, 2'd2};
    tbl[7]  = '{1, 10'h005, 1, 0, 50'h0, 0, 0, 2'd0};
    tbl[8]  = '{1, 10'h039, 1, 0, 50'h0, 0, 0, 2'd0};
    tbl[9]  = '{1, 10'h111, 1, 0, 50'h0, 0, 0, 2'd0};
    tbl[10] = '{1, 10'h222, 1, 0, 50'h0, 0, 1, 2'd0};
    tbl[11] = '{1, 10'h029, 1, 0, 50'h0, 0, 0, 2'd0};
    tbl[12] = '{1, 10'h2CC, 1, 1, {10'h029, 10'h2CC, 30'h0}, 1, 0, 2'd0};
    tbl[13] = '{0, 10'h000, 1, 0, 50'h0, 0, 0, 2'd0};

    m_reset();
    #2 rst_n = 1'b0;
    #1 chk_reset_vals("rst0");
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;

    for (int i = 0; i < 14; i++) begin
      step(tbl[i].v, tbl[i].b, tbl[i].r);
      chk($sformatf("tbl%0d_vld", i), out_vld, tbl[i].e_vld);
      if (tbl[i].e_vld) chk($sformatf("tbl%0d_wr", i), out_wr, tbl[i].e_wr);
      chk($sformatf("tbl%0d_wd", i), wdone, tbl[i].e_wd);
      chk($sformatf("tbl%0d_err", i), err, tbl[i].e_er);
      if (tbl[i].e_er) chk($sformatf("tbl%0d_code", i), err_code, tbl[i].e_code);
    end

    wd_cnt = 0;
    step(1, 10'h022, 1);
    step(1, 10'h101, 1);
    step(1, 10'h0FF, 1);
    step(1, 10'h102, 1);
    step(0, 10'h000, 1);
    step(1, 10'h103, 1);
    step(1, 10'h204, 1);
    chk("multi_wr", out_wr, {10'h022, 10'h101, 10'h102, 10'h103, 10'h204});
    step(0, 10'h000, 1);
    chk("multi_wdone_cnt", wd_cnt, 4);

    step(1, 10'h02A, 1);
    step(1, 10'h155, 1);
    chk("miss_err", err, 1);
    chk("miss_code", err_code, 1);
    chk("miss_wd", wdone, 0);
    step(1, 10'h030, 1);
    step(1, 10'h3AA, 1);
    chk("ct3_err", err, 1);
    chk("ct3_code", err_code, 1);

    step(1, 10'h028, 0);
    step(1, 10'h211, 0);
    chk("bp_first", out_wr, {10'h028, 10'h211, 30'h0});
    step(1, 10'h028, 0);
    step(1, 10'h222, 0);
    chk("bp_rdy0a", last_rdy, 0);
    step(1, 10'h222, 0);
    chk("bp_rdy0b", last_rdy, 0);
    chk("bp_hold", out_wr, {10'h028, 10'h211, 30'h0});
    step(1, 10'h222, 1);
    chk("bp_rdy1", last_rdy, 1);
    chk("bp_vld", out_vld, 1);
    chk("bp_second", out_wr, {10'h028, 10'h222, 30'h0});
    step(0, 10'h000, 1);
    chk("bp_drain", out_vld, 0);

`ifdef PWR_RX_TIMEOUT_EN
    step(1, 10'h030, 1);
    repeat (63) step(0, 10'h000, 1);
    chk("tmo_early", err, 0);
    step(0, 10'h000, 1);
    chk("tmo_err", err, 1);
    chk("tmo_code", err_code, 3);
`else
    step(1, 10'h030, 1);
    repeat (80) step(0, 10'h000, 1);
    chk("notmo_err", err, 0);
    step(1, 10'h1AA, 1);
    step(1, 10'h2BB, 1);
    chk("notmo_vld", out_vld, 1);
    chk("notmo_wr", out_wr, {10'h030, 10'h1AA, 10'h2BB, 20'h0});
`endif

    step(1, 10'h022, 1);
    step(1, 10'h155, 1);
    @(negedge clk);
    in_vld = 1'b0;
    #2 rst_n = 1'b0;
    #1 chk_reset_vals("rstmid");
    m_reset();
    @(negedge clk) rst_n = 1'b1;

    for (int i = 0; i < 3000; i++) begin
      rv = ($urandom_range(0, 9) < 8);
      rr = ($urandom_range(0, 9) < 7);
      if (!m_busy) begin
        rb[9:6] = 4'($urandom);
        rb[5]   = ($urandom_range(0, 9) < 9);
        rb[4:3] = 2'($urandom);
        rb[2:0] = ($urandom_range(0, 5) == 0) ?
                  3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
      end else begin
        case ($urandom_range(0, 19))
          0, 1, 2:  rct = 2'd0;
          3:        rct = 2'd3;
          4, 5, 6, 7, 8, 9: rct = 2'd2;
          default:  rct = 2'd1;
        endcase
        rb = {rct, 8'($urandom)};
      end
      step(rv, rb, rr);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
